// File: rtl/ulisp_uart_regs.sv
// Register-bus UART for the ulisp core: TX FIFO feeding an 8N1 serialiser, RX deserialiser with status.
// Reads are registered (1 cycle); TX pushes into a full FIFO are dropped unless a pop frees a slot that cycle.
module ulisp_uart_regs #(
  parameter int TX_FIFO_DEPTH   = 8,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int              AW        = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0]     FIFO_FULL = (AW+1)'(TX_FIFO_DEPTH);
  localparam logic [15:0]     DIV_RESET = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  typedef struct packed {
    logic overrun;
    logic rx_valid;
    logic tx_full;
    logic tx_empty;
  } status_t;

  logic rd_sel0, wr_sel0, wr_sel1, wr_sel2;
  assign rd_sel0 = register_read  && (register_index == 7'd0);
  assign wr_sel0 = register_write && (register_index == 7'd0);
  assign wr_sel1 = register_write && (register_index == 7'd1);
  assign wr_sel2 = register_write && (register_index == 7'd2);

  logic [15:0] div_q;
  logic [15:0] rd_q, rd_d;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, overrun_q;

  // TX FIFO
  logic [7:0]    fifo_mem_q [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (count_q == '0);
  assign tx_full  = (count_q == FIFO_FULL);
  assign tx_push  = wr_sel0 && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem_q[wr_ptr_q] <= register_write_value[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (tx_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (tx_push && !tx_pop)      count_q <= count_q + 1'b1;
      else if (!tx_push && tx_pop) count_q <= count_q - 1'b1;
    end
  end

  // TX serialiser; each bit latches the divisor so a change lands on the next boundary
  uart_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_bd_q, tx_bd_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_bd_q - 16'd1);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bd_d  = tx_bd_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = fifo_mem_q[rd_ptr_q];
          tx_st_d  = S_START;
          tx_cnt_d = '0;
          tx_bd_d  = div_q;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_st_d  = S_DATA;
          tx_cnt_d = '0;
          tx_bd_d  = div_q;
          tx_bit_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_bd_d  = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          // Chain straight into the next start bit when a byte is waiting
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = fifo_mem_q[rd_ptr_q];
            tx_st_d  = S_START;
            tx_cnt_d = '0;
            tx_bd_d  = div_q;
          end else begin
            tx_st_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
    case (tx_st_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_sh_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_bd_q   <= DIV_RESET;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bd_q   <= tx_bd_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_line_q <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;

  // RX: two sync flops plus one more stage for falling-edge detection
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_bd_q, rx_bd_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_done, rx_bit_end, rx_half;

  assign rx_bit_end = (rx_cnt_q == rx_bd_q - 16'd1);
  assign rx_half    = (rx_cnt_q == {1'b0, rx_bd_q[15:1]});

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bd_d  = rx_bd_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = '0;
          rx_bd_d  = div_q;
        end
      end
      S_START: begin
        if (rx_half) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_done = rx_s2_q;
          rx_st_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bd_q  <= DIV_RESET;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_s1_q  <= uart_rx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bd_q  <= rx_bd_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // Register file; reads see pre-edge state, a completing byte beats a same-cycle read
  status_t status;
  assign status = '{overrun: overrun_q, rx_valid: rx_valid_q, tx_full: tx_full, tx_empty: tx_empty};

  always_comb begin
    rd_d = rd_q;
    if (register_read) begin
      case (register_index)
        7'd0:    rd_d = {8'h00, rx_data_q};
        7'd1:    rd_d = {12'h000, status};
        7'd2:    rd_d = div_q;
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q       <= '0;
      div_q      <= DIV_RESET;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (wr_sel2) div_q <= (register_write_value < 16'd4) ? 16'd4 : register_write_value;
      if (rx_done) begin
        rx_data_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (rd_sel0) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_done && rx_valid_q && !rd_sel0)          overrun_q <= 1'b1;
      else if (wr_sel1 && register_write_value[3])    overrun_q <= 1'b0;
    end
  end

  assign register_read_value = rd_q;

endmodule
